// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: host-side burst controller for a single-port asynchronous RAM.
// A host request (address, length, direction) is turned into one RAM access per
// word. Writes are paced by wd_valid; every read takes an issue cycle, a hold
// cycle and an output cycle.
// Optional feature macro: RAM_ACCESS_CTRL_BURST_EN (honour req_len, 1..16 words).
// When it is left undefined, every request moves exactly one word.
module ram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic                  wd_valid,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  wd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rw,
    output logic                  ram_cs,
    output logic                  ram_oe
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_HOLD  = 3'd3,
        RD_OUT   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic                    w_accept;
    logic                    w_word_done;
    logic                    w_last;
    logic                    w_drive;

    // A request is taken only while idle; a word completes on a write edge or a read handshake.
    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_word_done = ((r_state == WR) && wd_valid) || ((r_state == RD_OUT) && rd_ready);

`ifdef RAM_ACCESS_CTRL_BURST_EN
    logic [3:0] r_cnt;

    // Remaining-word counter: loaded with req_len, decremented per completed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= req_len;
        end else if (w_word_done) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_last = (r_cnt == 4'd0);
`else
    logic w_unused_len;

    // Single-word build: the length field is deliberately not used.
    assign w_unused_len = ^req_len;
    assign w_last       = 1'b1;
`endif

    // State register; reset drops the state to IDLE at once so ram_cs falls asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = req_we ? WR : RD_ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            WR: begin
                if (wd_valid && w_last) begin
                    w_next = IDLE;
                end else begin
                    w_next = WR;
                end
            end
            RD_ISSUE: w_next = RD_HOLD;
            RD_HOLD:  w_next = RD_OUT;
            RD_OUT: begin
                if (rd_ready) begin
                    w_next = w_last ? IDLE : RD_ISSUE;
                end else begin
                    w_next = RD_OUT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address pointer and read capture; the address wraps naturally at 2^ADDR_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
            end else if (w_word_done) begin
                r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_addr <= r_addr;
            end
            if (r_state == RD_HOLD) begin
                r_rd_data <= ram_data;
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    // Per-state RAM strobes and host handshakes, decoded from the state register.
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        wd_ready  = 1'b0;
        rd_valid  = 1'b0;
        ram_cs    = 1'b0;
        ram_oe    = 1'b0;
        ram_rw    = 1'b0;
        w_drive   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            WR: begin
                ram_cs   = wd_valid;
                ram_rw   = wd_valid;
                wd_ready = wd_valid;
                w_drive  = wd_valid;
            end
            RD_ISSUE, RD_HOLD: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            RD_OUT: begin
                rd_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    assign ram_addr = r_addr;
    assign rd_data  = r_rd_data;
    // The bus is only driven during a write strobe, never while ram_oe is high.
    assign ram_data = w_drive ? wd_data : {DATA_WIDTH{1'bz}};

endmodule
